// File: rtl/drap_pkg.sv
// Shared defaults for the DRAP data memory.
package drap_pkg;

    localparam int DRAP_DATA_W = 32;
    localparam int DRAP_ADDR_W = 4;
    localparam int DRAP_DEPTH  = 2 ** DRAP_ADDR_W;

endpackage : drap_pkg

// File: rtl/drap_dmemory.sv
// DRAP data memory: a word-addressed flop array with an asynchronous clear
// and a registered read port. A write wins over a read on the same edge,
// and there is no write-through to data_out.
module drap_dmemory
    import drap_pkg::*;
#(
    parameter int DATA_W = DRAP_DATA_W,
    parameter int ADDR_W = DRAP_ADDR_W,
    parameter int DEPTH  = DRAP_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] data_out
);

    // Flops rather than a RAM macro, so the whole array can clear asynchronously.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  word_sel;
    logic              read_en;

    // One-hot write select: a word is only selected while write is high.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (write && (address == ADDR_W'(i))) begin
                word_sel[i] = 1'b1;
            end
        end
    end

    // A read is honoured only when it does not collide with a write.
    assign read_en = read && !write;

    // Write process: clear every word on reset, otherwise update the selected word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_sel[i]) begin
                    mem[i] <= data_in;
                end
            end
        end
    end

    // Read process: registered output that holds unless a lone read is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (read_en) begin
            data_out <= mem[address];
        end
    end

    // Flag unknown control levels in simulation; synthesis ignores this check.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({write, read}));
        end
    end

endmodule : drap_dmemory

// File: tb/tb_drap_dmemory.sv
// Directed self-checking bench for drap_dmemory.
module tb_drap_dmemory;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic [3:0]  address;
    logic        write;
    logic        read;
    logic [31:0] data_out;

    int n_checks;
    int n_fail;

    drap_dmemory #(
        .DATA_W (32),
        .ADDR_W (4),
        .DEPTH  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .address  (address),
        .write    (write),
        .read     (read),
        .data_out (data_out)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one operation on the falling edge, then let it take effect on the
    // rising edge and return 1 ns later. A wider address is truncated to 4 bits.
    task automatic applyStimulus(input int a, input logic [31:0] d,
                                 input logic w, input logic r);
        @(negedge clk);
        address = 4'(a);
        data_in = d;
        write   = w;
        read    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data_out: got %h expected %h", data_out, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            applyStimulus(a, 32'h0, 1'b0, 1'b1);
            n_checks++;
            if (data_out !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_read_%0d: got %h expected %h", a, data_out, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        applyStimulus(0, 32'h5555_5555, 1'b1, 1'b0);
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL write_only_holds: got %h expected %h", data_out, 32'h0);
        end
        applyStimulus(0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'h5555_5555) begin
            n_fail++;
            $display("[TB] FAIL read_addr0: got %h expected %h", data_out, 32'h5555_5555);
        end
    endtask

    task automatic test_second_word();
        applyStimulus(1, 32'hAAAA_AAAA, 1'b1, 1'b0);
        applyStimulus(1, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'hAAAA_AAAA) begin
            n_fail++;
            $display("[TB] FAIL read_addr1: got %h expected %h", data_out, 32'hAAAA_AAAA);
        end
        // data_in is driven to a distinct value during the read to show reads never write.
        applyStimulus(0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'h5555_5555) begin
            n_fail++;
            $display("[TB] FAIL reread_addr0: got %h expected %h", data_out, 32'h5555_5555);
        end
        applyStimulus(0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'h5555_5555) begin
            n_fail++;
            $display("[TB] FAIL addr0_untouched: got %h expected %h", data_out, 32'h5555_5555);
        end
    endtask

    task automatic test_truncation_hold();
        applyStimulus(126, 32'h5555_5555, 1'b1, 1'b0);
        applyStimulus(127, 32'hAAAA_AAAA, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(3, 32'h0, 1'b0, 1'b0);
            n_checks++;
            if (data_out !== 32'h5555_5555) begin
                n_fail++;
                $display("[TB] FAIL idle_hold_%0d: got %h expected %h", c, data_out, 32'h5555_5555);
            end
        end
        applyStimulus(14, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'h5555_5555) begin
            n_fail++;
            $display("[TB] FAIL read_addr14: got %h expected %h", data_out, 32'h5555_5555);
        end
        applyStimulus(15, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'hAAAA_AAAA) begin
            n_fail++;
            $display("[TB] FAIL read_addr15: got %h expected %h", data_out, 32'hAAAA_AAAA);
        end
    endtask

    task automatic test_write_priority();
        applyStimulus(2, 32'h1234_5678, 1'b1, 1'b1);
        n_checks++;
        if (data_out !== 32'hAAAA_AAAA) begin
            n_fail++;
            $display("[TB] FAIL collide_holds: got %h expected %h", data_out, 32'hAAAA_AAAA);
        end
        applyStimulus(2, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'h1234_5678) begin
            n_fail++;
            $display("[TB] FAIL read_addr2: got %h expected %h", data_out, 32'h1234_5678);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1, 32'h0, 1'b0, 1'b1);
        // Assert reset between edges; data_out must clear without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL async_clear: got %h expected %h", data_out, 32'h0);
        end
        // Operations presented while held in reset must be ignored.
        applyStimulus(3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(3, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL read_in_reset: got %h expected %h", data_out, 32'h0);
        end
        // The very first edge after release performs a write.
        @(negedge clk);
        rst_n   = 1'b1;
        address = 4'd5;
        data_in = 32'hCAFE_F00D;
        write   = 1'b1;
        read    = 1'b0;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            logic [31:0] exp;
            exp = (a == 5) ? 32'hCAFE_F00D : 32'h0;
            applyStimulus(a, 32'h0, 1'b0, 1'b1);
            n_checks++;
            if (data_out !== exp) begin
                n_fail++;
                $display("[TB] FAIL post_reset_read_%0d: got %h expected %h", a, data_out, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        data_in  = '0;
        address  = '0;
        write    = 1'b0;
        read     = 1'b0;

        test_reset();
        test_write_read();
        test_second_word();
        test_truncation_hold();
        test_write_priority();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_drap_dmemory
